alpharetz_spi_cmd_queue: RTL and testbench

Upstream feeder for `alpharetz_spi_controller`. Buffers SPI write commands (payload plus peripheral address) from the system side in a small FIFO. Issues them one at a time to the controller as a single-cycle `start_txn` pulse with stable `tx_data`/`p_addr`. Waits for `end_txn` and enforces a minimum inter-transaction gap, with an optional completion timeout.

---
 rtl/alpharetz_spi_pkg.sv | 20 ++
 rtl/alpharetz_sync_fifo.sv | 76 +++++++
 rtl/alpharetz_spi_cmd_queue.sv | 169 ++++++++++++++++
 tb/tb_alpharetz_spi_cmd_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpharetz_spi_pkg.sv
// Shared types for the alpharetz SPI command path: queue FSM states,
// default controller widths and the packed command record stored in the FIFO.
package alpharetz_spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned P_ADDR_WIDTH_DEFAULT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } spi_cmdq_state_t;

  typedef struct packed {
    logic [P_ADDR_WIDTH_DEFAULT-1:0]   addr;
    logic [SPI_DATA_WIDTH_DEFAULT-1:0] data;
  } spi_cmd_t;

endpackage

// File: rtl/alpharetz_sync_fifo.sv
// Single-clock FIFO with clock enable, flush and occupancy output.
// Push is refused when full even if a pop happens on the same edge; flush
// empties the FIFO and wins over any push or pop on that edge.
module alpharetz_sync_fifo #(
  parameter type         data_t = logic [7:0],
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  data_t                  wdata_i,
  output data_t                  rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  data_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (en_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alpharetz_spi_cmd_queue.sv
// Command queue feeding alpharetz_spi_controller: buffers {data, addr}
// commands, issues them one at a time with a one-cycle start_txn pulse, waits
// for end_txn and enforces an idle gap before the next issue.
// Optional completion timeout: define ALPHARETZ_SPI_CMDQ_TIMEOUT_EN.
module alpharetz_spi_cmd_queue
  import alpharetz_spi_pkg::*;
#(
  parameter int unsigned SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEFAULT,
  parameter int unsigned P_ADDR_WIDTH   = P_ADDR_WIDTH_DEFAULT,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      sys_clk,
  input  logic                      async_rst_n,
  input  logic                      sys_clk_en,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SPI_DATA_WIDTH-1:0] cmd_data,
  input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic                      start_txn,
  output logic [SPI_DATA_WIDTH-1:0] tx_data,
  output logic [P_ADDR_WIDTH-1:0]   p_addr,
  input  logic                      end_txn,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      timeout_err
);

  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GAP_CYCLES[GW-1:0];

  spi_cmdq_state_t           state_q, state_d;
  logic                      start_q, start_d;
  logic [SPI_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [P_ADDR_WIDTH-1:0]   p_addr_q, p_addr_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      pop_req;
  logic                      to_fire;

  spi_cmd_t fifo_wdata, fifo_rdata;
  logic     fifo_full, fifo_empty;

  assign fifo_wdata.addr = cmd_addr;
  assign fifo_wdata.data = cmd_data;

  alpharetz_sync_fifo #(
    .data_t (spi_cmd_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (async_rst_n),
    .en_i    (sys_clk_en),
    .push_i  (cmd_valid),
    .pop_i   (pop_req),
    .flush_i (flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign cmd_ready = ~fifo_full;
  assign start_txn = start_q;
  assign tx_data   = tx_data_q;
  assign p_addr    = p_addr_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef ALPHARETZ_SPI_CMDQ_TIMEOUT_EN
  localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned   TO_LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [TW-1:0] TO_LAST   = TO_LAST_I[TW-1:0];

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;

  // Timeout counter: zeroed while issuing so it starts fresh on WAIT entry;
  // fires on the enabled cycle that would complete TIMEOUT_CYCLES in WAIT.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_fire  = 1'b0;
    if (state_q == ST_ISSUE) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT && !end_txn) begin
      if (to_cnt_q == TO_LAST) to_fire = 1'b1;
      else                     to_cnt_d = to_cnt_q + 1'b1;
    end
    err_d = (err_q & ~err_clr) | to_fire;
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (sys_clk_en) begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign to_fire        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Issue sequencing: pop and launch, wait for completion, then hold off.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    p_addr_d  = p_addr_q;
    gap_d     = gap_q;
    pop_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !flush) begin
          state_d   = ST_ISSUE;
          pop_req   = 1'b1;
          start_d   = 1'b1;
          tx_data_d = fifo_rdata.data;
          p_addr_d  = fifo_rdata.addr;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (end_txn || to_fire) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, start pulse, held command outputs and gap counter.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      tx_data_q <= '0;
      p_addr_q  <= '0;
      gap_q     <= '0;
    end else if (sys_clk_en) begin
      state_q   <= state_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
      p_addr_q  <= p_addr_d;
      gap_q     <= gap_d;
    end
  end

endmodule

// File: tb/tb_alpharetz_spi_cmd_queue.sv
// Directed bench for alpharetz_spi_cmd_queue (DEPTH=4, GAP_CYCLES=2,
// TIMEOUT_CYCLES=16). Timeout expectations follow ALPHARETZ_SPI_CMDQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_alpharetz_spi_cmd_queue;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned TO    = 16;

  logic          sys_clk = 1'b0;
  logic          async_rst_n;
  logic          sys_clk_en;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] cmd_addr;
  logic          flush;
  logic          err_clr;
  logic          start_txn;
  logic [DW-1:0] tx_data;
  logic [AW-1:0] p_addr;
  logic          end_txn;
  logic          busy;
  logic [2:0]    level;
  logic          timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        seen;

  always #5 sys_clk = ~sys_clk;

  alpharetz_spi_cmd_queue #(
    .SPI_DATA_WIDTH (DW),
    .P_ADDR_WIDTH   (AW),
    .DEPTH          (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk     (sys_clk),
    .async_rst_n (async_rst_n),
    .sys_clk_en  (sys_clk_en),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_addr    (cmd_addr),
    .flush       (flush),
    .err_clr     (err_clr),
    .start_txn   (start_txn),
    .tx_data     (tx_data),
    .p_addr      (p_addr),
    .end_txn     (end_txn),
    .busy        (busy),
    .level       (level),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // From ISSUE or WAIT: complete the current transaction and expect the next
  // start exactly GAP+2 edges after the end_txn edge.
  task automatic complete_expect(input string tag, input logic [DW-1:0] d,
                                 input logic [AW-1:0] a, input logic [2:0] lvl);
    step();
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    step();
    step();
    step();
    check({tag, "_gap_quiet"}, 32'(start_txn), 32'd0);
    step();
    check({tag, "_start"}, 32'(start_txn), 32'd1);
    check({tag, "_data"}, 32'(tx_data), 32'(d));
    check({tag, "_addr"}, 32'(p_addr), 32'(a));
    check({tag, "_level"}, 32'(level), 32'(lvl));
  endtask

  // From ISSUE or WAIT with nothing queued: complete and expect idle.
  task automatic finish_txn(input string tag);
    step();
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    step();
    step();
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_lvl [5];
    exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    async_rst_n = 1'b0;
    sys_clk_en  = 1'b1;
    cmd_valid   = 1'b0;
    cmd_data    = '0;
    cmd_addr    = '0;
    flush       = 1'b0;
    err_clr     = 1'b0;
    end_txn     = 1'b0;
    step();
    step();
    check("rst_start", 32'(start_txn), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_p_addr", 32'(p_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    async_rst_n = 1'b1;
    step();

    // Single command into an empty idle queue.
    cmd_valid = 1'b1; cmd_data = 8'hA5; cmd_addr = 3'd2;
    step();
    cmd_valid = 1'b0;
    check("t1_level_e0", 32'(level), 32'd1);
    check("t1_start_e0", 32'(start_txn), 32'd0);
    check("t1_busy_e0", 32'(busy), 32'd0);
    step();
    check("t1_start_e1", 32'(start_txn), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'hA5);
    check("t1_p_addr", 32'(p_addr), 32'd2);
    check("t1_busy_e1", 32'(busy), 32'd1);
    check("t1_level_e1", 32'(level), 32'd0);
    step();
    check("t1_start_e2", 32'(start_txn), 32'd0);
    repeat (3) step();
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    step();
    step();
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    step();
    check("t1_busy_after_gap", 32'(busy), 32'd0);

    // Five back-to-back pushes into DEPTH=4 with completion withheld.
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_data = 8'(8'h30 + i);
      cmd_addr = 3'(i);
      step();
      check($sformatf("t2_level_%0d", i), 32'(level), 32'(exp_lvl[i]));
      if (i == 1) begin
        check("t2_first_start", 32'(start_txn), 32'd1);
        check("t2_first_data", 32'(tx_data), 32'h30);
      end
    end
    check("t2_ready_full", 32'(cmd_ready), 32'd0);
    cmd_data = 8'h35; cmd_addr = 3'd5;
    step();
    check("t2_stall_level", 32'(level), 32'd4);
    check("t2_stall_ready", 32'(cmd_ready), 32'd0);
    step();
    check("t2_stall_level2", 32'(level), 32'd4);
    cmd_valid = 1'b0;
    for (int j = 1; j < 5; j++) begin
      complete_expect($sformatf("t2_c%0d", j), 8'(8'h30 + j), 3'(j), 3'(4 - j));
      if (j == 1) check("t2_ready_after_pop", 32'(cmd_ready), 32'd1);
    end
    finish_txn("t2");
    seen = 1'b0;
    repeat (5) begin
      step();
      if (start_txn) seen = 1'b1;
    end
    check("t2_no_sixth_issue", 32'(seen), 32'd0);

    // end_txn outside WAIT is ignored; exact gap after a WAIT completion.
    cmd_valid = 1'b1; cmd_data = 8'h11; cmd_addr = 3'd1;
    step();
    cmd_data = 8'h22; cmd_addr = 3'd3;
    step();
    cmd_valid = 1'b0;
    check("t3_start", 32'(start_txn), 32'd1);
    check("t3_data", 32'(tx_data), 32'h11);
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      step();
      if (start_txn || !busy) seen = 1'b1;
    end
    check("t3_end_in_issue_ignored", 32'(seen), 32'd0);
    end_txn = 1'b1;
    step();
    step();
    end_txn = 1'b0;
    step();
    check("t3_gap_quiet_k2", 32'(start_txn), 32'd0);
    step();
    check("t3_gap_quiet_k3", 32'(start_txn), 32'd0);
    step();
    check("t3_start_k4", 32'(start_txn), 32'd1);
    check("t3_data2", 32'(tx_data), 32'h22);
    check("t3_addr2", 32'(p_addr), 32'd3);
    finish_txn("t3");

    // Flush while a transaction is in WAIT.
    cmd_valid = 1'b1; cmd_data = 8'h41; cmd_addr = 3'd4;
    step();
    cmd_data = 8'h42; cmd_addr = 3'd5;
    step();
    cmd_data = 8'h43; cmd_addr = 3'd6;
    step();
    cmd_valid = 1'b0;
    check("t4_level_before", 32'(level), 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_level_flushed", 32'(level), 32'd0);
    check("t4_ready_flushed", 32'(cmd_ready), 32'd1);
    check("t4_busy_kept", 32'(busy), 32'd1);
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    step();
    step();
    step();
    check("t4_idle", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (start_txn) seen = 1'b1;
    end
    check("t4_no_issue", 32'(seen), 32'd0);
    check("t4_tx_held", 32'(tx_data), 32'h41);
    check("t4_addr_held", 32'(p_addr), 32'd4);
    cmd_valid = 1'b1; flush = 1'b1; cmd_data = 8'h77;
    step();
    cmd_valid = 1'b0; flush = 1'b0;
    check("t4_push_dropped", 32'(level), 32'd0);
    step();
    check("t4_still_idle", 32'(busy), 32'd0);

    // Completion never arrives.
    cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_addr = 3'd7;
    step();
    cmd_data = 8'h5B; cmd_addr = 3'd0;
    step();
    cmd_valid = 1'b0;
    check("t5_start", 32'(start_txn), 32'd1);
    check("t5_data", 32'(tx_data), 32'h5A);
    step();
`ifdef ALPHARETZ_SPI_CMDQ_TIMEOUT_EN
    seen = 1'b0;
    repeat (15) begin
      step();
      if (timeout_err || start_txn) seen = 1'b1;
    end
    check("t5_no_early_timeout", 32'(seen), 32'd0);
    step();
    check("t5_timeout_err", 32'(timeout_err), 32'd1);
    check("t5_busy_gap", 32'(busy), 32'd1);
    step();
    step();
    step();
    check("t5_gap_quiet", 32'(start_txn), 32'd0);
    step();
    check("t5_next_start", 32'(start_txn), 32'd1);
    check("t5_next_data", 32'(tx_data), 32'h5B);
    check("t5_next_addr", 32'(p_addr), 32'd0);
    check("t5_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_err_cleared", 32'(timeout_err), 32'd0);
`else
    seen = 1'b0;
    repeat (40) begin
      step();
      if (start_txn || !busy || timeout_err) seen = 1'b1;
    end
    check("t5_wait_holds", 32'(seen), 32'd0);
    complete_expect("t5", 8'h5B, 3'd0, 3'd0);
`endif
    finish_txn("t5");

    // Clock enable freezes the start pulse and the gap count.
    cmd_valid = 1'b1; cmd_data = 8'h66; cmd_addr = 3'd1;
    step();
    cmd_data = 8'h67; cmd_addr = 3'd2;
    step();
    cmd_valid = 1'b0;
    check("t6_start", 32'(start_txn), 32'd1);
    sys_clk_en = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (!start_txn || level != 3'd1 || tx_data != 8'h66) seen = 1'b1;
    end
    check("t6_pulse_frozen", 32'(seen), 32'd0);
    sys_clk_en = 1'b1;
    step();
    check("t6_pulse_ends", 32'(start_txn), 32'd0);
    step();
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    step();
    sys_clk_en = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (start_txn || !busy) seen = 1'b1;
    end
    check("t6_gap_frozen", 32'(seen), 32'd0);
    sys_clk_en = 1'b1;
    step();
    step();
    check("t6_gap_quiet", 32'(start_txn), 32'd0);
    step();
    check("t6_resume_start", 32'(start_txn), 32'd1);
    check("t6_resume_data", 32'(tx_data), 32'h67);
    check("t6_resume_addr", 32'(p_addr), 32'd2);

    // Asynchronous reset in the middle of a transaction with a queued command.
    cmd_valid = 1'b1; cmd_data = 8'h88; cmd_addr = 3'd3;
    step();
    cmd_valid = 1'b0;
    check("t7_level_before", 32'(level), 32'd1);
    #2;
    async_rst_n = 1'b0;
    #1;
    check("t7_rst_level", 32'(level), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_tx_data", 32'(tx_data), 32'd0);
    check("t7_rst_ready", 32'(cmd_ready), 32'd1);
    step();
    async_rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (start_txn || busy) seen = 1'b1;
    end
    check("t7_queue_lost", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
